// File: rtl/mips_memory2.sv
// Word-organised burst memory for the MIPS datapath, mapped at START_ADDR (big-endian words).
// Latency: write stored / read data on dout at the edge of each beat; beat k is k edges after accept.
// Backpressure: none; busy is high while later burst beats run, and new requests then are ignored.
module mips_memory2 #(
    parameter logic [31:0] START_ADDR = 32'h8002_0000,
    parameter int          MEM_BYTES  = 1048576
) (
    input  logic        clk,
    input  logic        rst_n,
    input  logic [31:0] addr,
    input  logic [31:0] din,
    output logic [31:0] dout,
    input  logic [1:0]  access_size,
    input  logic        rw,
    output logic        busy,
    input  logic        enable
);

    localparam int          WORDS = MEM_BYTES / 4;
    localparam int          IDX_W = (WORDS > 1) ? $clog2(WORDS) : 1;
    localparam logic [31:0] LIMIT = 32'(MEM_BYTES);

    typedef enum logic {
        IDLE,
        BURST
    } state_t;

    state_t      state_q, state_d;
    logic [31:0] ptr_q, ptr_d;      // byte address of the next burst beat
    logic [3:0]  rem_q, rem_d;      // beats still to perform after the current edge's beat
    logic        rw_q, rw_d;
    logic [31:0] dout_q;

    logic [31:0] mem [WORDS];

    // Beat issued at the coming edge: either the accepted request or the next burst word.
    logic             beat_vld;
    logic             beat_rw;
    logic [31:0]      beat_addr;
    logic [31:0]      offset;
    logic             in_range;
    logic [IDX_W-1:0] idx;
    logic             wr_en;
    logic             rd_en;
    logic [3:0]       extra_beats;

    // Burst length minus one for the requested access size.
    always_comb begin
        extra_beats = 4'd0;
        case (access_size)
            2'b00:   extra_beats = 4'd0;
            2'b01:   extra_beats = 4'd3;
            2'b10:   extra_beats = 4'd7;
            default: extra_beats = 4'd15;
        endcase
    end

    // Next-state logic: accept in IDLE, then step the pointer once per edge until the last beat.
    always_comb begin
        state_d   = state_q;
        ptr_d     = ptr_q;
        rem_d     = rem_q;
        rw_d      = rw_q;
        beat_vld  = 1'b0;
        beat_rw   = rw;
        beat_addr = addr & 32'hFFFF_FFFC;
        case (state_q)
            IDLE: begin
                if (enable) begin
                    beat_vld = 1'b1;
                    if (extra_beats != 4'd0) begin
                        state_d = BURST;
                        ptr_d   = beat_addr + 32'd4;
                        rem_d   = extra_beats;
                        rw_d    = rw;
                    end
                end
            end
            BURST: begin
                beat_vld  = 1'b1;
                beat_rw   = rw_q;
                beat_addr = ptr_q;
                ptr_d     = ptr_q + 32'd4;
                rem_d     = rem_q - 4'd1;
                if (rem_q == 4'd1) begin
                    state_d = IDLE;
                end
            end
            default: state_d = IDLE;
        endcase
    end

    // Modular offset from the base makes addresses below START_ADDR land far out of range.
    assign offset   = beat_addr - START_ADDR;
    assign in_range = (offset < LIMIT);
    assign idx      = offset[IDX_W+1:2];
    assign wr_en    = beat_vld & beat_rw & in_range;
    assign rd_en    = beat_vld & ~beat_rw;

    // Control state register; reset aborts any burst in flight.
    always_ff @(posedge clk) begin
        if (!rst_n) begin
            state_q <= IDLE;
            ptr_q   <= 32'd0;
            rem_q   <= 4'd0;
            rw_q    <= 1'b0;
        end else begin
            state_q <= state_d;
            ptr_q   <= ptr_d;
            rem_q   <= rem_d;
            rw_q    <= rw_d;
        end
    end

    // Storage write; contents survive reset, but the beat on a reset edge is dropped.
    always_ff @(posedge clk) begin
        if (rst_n && wr_en) begin
            mem[idx] <= din;
        end
    end

    // Registered read port; out-of-range reads return zero, idle cycles hold the last value.
    always_ff @(posedge clk) begin
        if (!rst_n) begin
            dout_q <= 32'd0;
        end else if (rd_en) begin
            dout_q <= in_range ? mem[idx] : 32'd0;
        end
    end

    assign dout = dout_q;
    assign busy = (state_q == BURST);

endmodule

// File: tb/tb_mips_memory2.sv
module tb_mips_memory2;

    localparam logic [31:0] SA = 32'h8002_0000;
    localparam int          MB = 1048576;

    logic        clk = 1'b0;
    logic        rst_n;
    logic [31:0] addr;
    logic [31:0] din;
    logic [31:0] dout;
    logic [1:0]  access_size;
    logic        rw;
    logic        busy;
    logic        enable;

    int n_cmp = 0;
    int n_err = 0;

    // Reference store: word index -> value, only for words the bench has written.
    logic [31:0] ref_mem [int unsigned];

    always #5 clk = ~clk;

    mips_memory2 #(.START_ADDR(SA), .MEM_BYTES(MB)) dut (
        .clk         (clk),
        .rst_n       (rst_n),
        .addr        (addr),
        .din         (din),
        .dout        (dout),
        .access_size (access_size),
        .rw          (rw),
        .busy        (busy),
        .enable      (enable)
    );

    function automatic bit in_rng(input logic [31:0] a);
        logic [31:0] o;
        o = a - SA;
        return o < 32'(MB);
    endfunction

    function automatic logic [31:0] exp_rd(input logic [31:0] a);
        logic [31:0] w;
        if (!in_rng(a)) return 32'd0;
        w = (a - SA) >> 2;
        return ref_mem[w];
    endfunction

    task automatic model_wr(input logic [31:0] a, input logic [31:0] d);
        logic [31:0] w;
        if (in_rng(a)) begin
            w = (a - SA) >> 2;
            ref_mem[w] = d;
        end
    endtask

    function automatic int blen(input logic [1:0] s);
        case (s)
            2'b00:   return 1;
            2'b01:   return 4;
            2'b10:   return 8;
            default: return 16;
        endcase
    endfunction

    task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        n_cmp++;
        assert (obs === exp)
        else begin
            n_err++;
            $error("FAIL %s: observed=%h expected=%h", tag, obs, exp);
        end
    endtask

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    task automatic noise_or_idle(input bit noise);
        if (noise) begin
            enable      = 1'($urandom);
            rw          = 1'($urandom);
            addr        = $urandom;
            access_size = 2'($urandom);
        end else begin
            enable = 1'b0;
        end
    endtask

    task automatic wr_burst(input logic [31:0] a, input logic [1:0] sz,
                            input logic [31:0] d [16], input bit noise);
        int n;
        logic [31:0] base;
        n    = blen(sz);
        base = a & 32'hFFFF_FFFC;
        enable = 1'b1; rw = 1'b1; addr = a; access_size = sz; din = d[0];
        tick();
        model_wr(base, d[0]);
        check("wr_busy_accept", {31'd0, busy}, {31'd0, n > 1});
        for (int k = 1; k < n; k++) begin
            noise_or_idle(noise);
            din = d[k];
            tick();
            model_wr(base + 32'(4 * k), d[k]);
            check("wr_busy_beat", {31'd0, busy}, {31'd0, k < n - 1});
        end
        enable = 1'b0;
    endtask

    task automatic rd_burst(input logic [31:0] a, input logic [1:0] sz, input bit noise);
        int n;
        logic [31:0] base;
        n    = blen(sz);
        base = a & 32'hFFFF_FFFC;
        enable = 1'b1; rw = 1'b0; addr = a; access_size = sz; din = $urandom;
        tick();
        check("rd_dout_beat0", dout, exp_rd(base));
        check("rd_busy_accept", {31'd0, busy}, {31'd0, n > 1});
        for (int k = 1; k < n; k++) begin
            noise_or_idle(noise);
            din = $urandom;
            tick();
            check("rd_dout_beat", dout, exp_rd(base + 32'(4 * k)));
            check("rd_busy_beat", {31'd0, busy}, {31'd0, k < n - 1});
        end
        enable = 1'b0;
    endtask

    task automatic rand_fill(output logic [31:0] d [16]);
        for (int i = 0; i < 16; i++) d[i] = $urandom | 32'd1;
    endtask

    initial begin
        logic [31:0] d [16];
        logic [31:0] a;
        logic [31:0] held;

        // Reset state
        rst_n = 1'b0; enable = 1'b0; rw = 1'b0; addr = 32'd0; din = 32'd0; access_size = 2'b00;
        tick();
        tick();
        check("reset_busy", {31'd0, busy}, 32'd0);
        check("reset_dout", dout, 32'd0);
        rst_n = 1'b1;

        // Single write then read
        for (int i = 0; i < 16; i++) d[i] = 32'd0;
        d[0] = 32'hDEAD_BEEF;
        wr_burst(SA, 2'b00, d, 1'b0);
        rd_burst(SA, 2'b00, 1'b0);
        check("single_rd_const", dout, 32'hDEAD_BEEF);

        // Idle with enable low: no write, dout holds
        held = dout;
        rw = 1'b1; din = 32'h0BAD_0BAD; addr = SA;
        tick();
        tick();
        check("idle_hold", dout, held);
        rd_burst(SA, 2'b00, 1'b0);

        // 4-word write burst and read back
        d[0] = 32'h1111_1111; d[1] = 32'h2222_2222; d[2] = 32'h3333_3333; d[3] = 32'h4444_4444;
        wr_burst(32'h8002_0010, 2'b01, d, 1'b0);
        rd_burst(32'h8002_0010, 2'b01, 1'b0);
        check("burst4_last_const", dout, 32'h4444_4444);

        // Program image load with junk requests while busy
        for (int b = 0; b < 12; b++) begin
            rand_fill(d);
            wr_burst(SA + 32'(16 * b), 2'b01, d, 1'b1);
        end
        for (int b = 0; b < 12; b++) begin
            rd_burst(SA + 32'(16 * b) + 32'(b % 4), 2'b01, 1'b1);
        end

        // 16-word burst 0..15, plus an 8-word random burst
        for (int i = 0; i < 16; i++) d[i] = 32'(i);
        wr_burst(32'h8002_0100, 2'b11, d, 1'b1);
        rd_burst(32'h8002_0100, 2'b11, 1'b0);
        check("burst16_last_const", dout, 32'd15);
        rand_fill(d);
        wr_burst(32'h8002_0200, 2'b10, d, 1'b1);
        rd_burst(32'h8002_0200, 2'b10, 1'b1);

        // Out of range reads and writes
        rand_fill(d);
        wr_burst(SA + 32'(MB) - 32'd4, 2'b00, d, 1'b0);
        rd_burst(SA, 2'b00, 1'b0);
        rd_burst(32'h8001_FFFC, 2'b00, 1'b0);
        check("oor_low_rd_zero", dout, 32'd0);
        rd_burst(SA + 32'(MB) - 32'd4, 2'b00, 1'b0);
        rd_burst(SA + 32'(MB), 2'b00, 1'b0);
        check("oor_high_rd_zero", dout, 32'd0);
        rand_fill(d);
        wr_burst(32'h8001_FFFC, 2'b00, d, 1'b0);
        rand_fill(d);
        wr_burst(SA + 32'(MB), 2'b00, d, 1'b0);
        rd_burst(SA, 2'b00, 1'b0);
        rd_burst(SA + 32'(MB) - 32'd4, 2'b00, 1'b0);
        // Burst straddling the top of memory: two in-range beats, two out of range
        rand_fill(d);
        wr_burst(SA + 32'(MB) - 32'd8, 2'b01, d, 1'b0);
        rd_burst(SA + 32'(MB) - 32'd8, 2'b01, 1'b0);
        rd_burst(SA, 2'b00, 1'b0);

        // Reset during beat 2 of a 4-word write
        a = SA + 32'h300;
        rand_fill(d);
        wr_burst(a, 2'b01, d, 1'b0);
        rd_burst(a + 32'd12, 2'b00, 1'b0);
        rand_fill(d);
        enable = 1'b1; rw = 1'b1; addr = a; access_size = 2'b01; din = d[0];
        tick();
        model_wr(a, d[0]);
        enable = 1'b0; din = d[1];
        tick();
        model_wr(a + 32'd4, d[1]);
        din = d[2]; rst_n = 1'b0;
        tick();
        check("midrst_busy", {31'd0, busy}, 32'd0);
        check("midrst_dout", dout, 32'd0);
        rst_n = 1'b1; din = d[3];
        tick();
        check("postrst_busy", {31'd0, busy}, 32'd0);
        rd_burst(a, 2'b01, 1'b0);
        rand_fill(d);
        wr_burst(a, 2'b01, d, 1'b0);
        rd_burst(a, 2'b01, 1'b0);

        $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_err);
        $finish;
    end

endmodule
